// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: GMII transmit framing stage (preamble/SFD, payload, optional pad, CRC32 FCS, IPG).
// Optional zero-padding to MIN_FRAME is compiled in with the macro GMII_TX_FRAMER_PAD_EN.
`timescale 1ns/1ps
`default_nettype none

module gmii_tx_framer #(
    parameter int IPG_BYTES = 12,
    parameter int MIN_FRAME = 60,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_err,
    output logic             in_ready,
    output logic             tx_en,
    output logic [7:0]       txd,
    output logic             tx_er,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
`ifdef GMII_TX_FRAMER_PAD_EN
        S_PAD  = 3'd4,
`endif
        S_FCS  = 3'd5,
        S_IPG  = 3'd6
    } state_t;

    localparam logic [7:0] c_ipg_last = 8'(IPG_BYTES - 1);

    if (IPG_BYTES < 1 || IPG_BYTES > 255 || MIN_FRAME < 0 || MIN_FRAME > 65535 || CNT_W < 1) begin : g_param_check
        $error("gmii_tx_framer: illegal parameter value");
    end

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [15:0]      r_bcnt;
    logic [31:0]      r_crc;
    logic [23:0]      r_fcs_sh;
    logic             r_last;
    logic             r_bad;
    logic             r_tx_en;
    logic [7:0]       r_txd;
    logic             r_tx_er;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_ready;
    logic [31:0]      w_crc_data;
    logic [31:0]      w_fcs;
    logic [15:0]      w_bcnt_inc;

    // Reflected CRC32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] f_crc8(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_data = f_crc8(r_crc, in_data);
    assign w_fcs      = ~r_crc;
    assign w_bcnt_inc = (r_bcnt == 16'hFFFF) ? r_bcnt : r_bcnt + 16'd1;

`ifdef GMII_TX_FRAMER_PAD_EN
    localparam logic [15:0] c_min_frame = 16'(MIN_FRAME);
    logic        w_need_pad;
    logic [31:0] w_crc_zero;
    assign w_need_pad = (r_bcnt < c_min_frame);
    assign w_crc_zero = f_crc8(r_crc, 8'h00);
`endif

    // IDLE swallows stray non-sop bytes; the sop byte itself is held until SFD.
    always_comb begin
        w_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_ready = !in_sop;
                S_SFD:   w_ready = 1'b1;
                S_DATA:  w_ready = !r_last;
                default: w_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_bcnt      <= 16'd0;
            r_crc       <= 32'hFFFF_FFFF;
            r_fcs_sh    <= 24'd0;
            r_last      <= 1'b0;
            r_bad       <= 1'b0;
            r_tx_en     <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_er     <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_sop) begin
                        r_state <= S_PRE;
                        r_tx_en <= 1'b1;
                        r_txd   <= 8'h55;
                        r_cnt   <= 8'd0;
                    end
                end
                S_PRE: begin
                    if (r_cnt == 8'd6) begin
                        r_state <= S_SFD;
                        r_txd   <= 8'hD5;
                        r_crc   <= 32'hFFFF_FFFF;
                        r_bcnt  <= 16'd0;
                        r_bad   <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SFD, S_DATA: begin
                    r_state <= S_DATA;
                    if (r_last) begin
                        r_last  <= 1'b0;
                        r_tx_er <= 1'b0;
`ifdef GMII_TX_FRAMER_PAD_EN
                        if (w_need_pad) begin
                            r_state <= S_PAD;
                            r_txd   <= 8'h00;
                            r_crc   <= w_crc_zero;
                            r_bcnt  <= w_bcnt_inc;
                        end else
`endif
                        begin
                            r_state  <= S_FCS;
                            r_txd    <= w_fcs[7:0];
                            r_fcs_sh <= w_fcs[31:8];
                            r_tx_er  <= r_bad;
                            r_cnt    <= 8'd0;
                        end
                    end else if (in_valid) begin
                        r_txd   <= in_data;
                        r_tx_er <= 1'b0;
                        r_crc   <= w_crc_data;
                        r_bcnt  <= w_bcnt_inc;
                        if (in_eop) begin
                            r_last <= 1'b1;
                            r_bad  <= r_bad | in_err;
                        end
                    end else begin
                        // Underrun: keep tx_en up, poison the frame, leave CRC/count alone.
                        r_txd   <= 8'h00;
                        r_tx_er <= 1'b1;
                        r_bad   <= 1'b1;
                    end
                end
`ifdef GMII_TX_FRAMER_PAD_EN
                S_PAD: begin
                    if (w_need_pad) begin
                        r_txd  <= 8'h00;
                        r_crc  <= w_crc_zero;
                        r_bcnt <= w_bcnt_inc;
                    end else begin
                        r_state  <= S_FCS;
                        r_txd    <= w_fcs[7:0];
                        r_fcs_sh <= w_fcs[31:8];
                        r_tx_er  <= r_bad;
                        r_cnt    <= 8'd0;
                    end
                end
`endif
                S_FCS: begin
                    if (r_cnt == 8'd3) begin
                        r_state     <= S_IPG;
                        r_tx_en     <= 1'b0;
                        r_txd       <= 8'h00;
                        r_tx_er     <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (r_bad) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt    <= r_cnt + 8'd1;
                        r_txd    <= r_fcs_sh[7:0];
                        r_fcs_sh <= r_fcs_sh >> 8;
                    end
                end
                S_IPG: begin
                    // A waiting sop skips the IDLE cycle so the gap is exactly IPG_BYTES.
                    if (r_cnt == c_ipg_last) begin
                        if (in_valid && in_sop) begin
                            r_state <= S_PRE;
                            r_tx_en <= 1'b1;
                            r_txd   <= 8'h55;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign tx_en     = r_tx_en;
    assign txd       = r_txd;
    assign tx_er     = r_tx_er;
    assign busy      = (r_state != S_IDLE);
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: table-driven frame vectors plus directed reset / back-to-back sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_gmii_tx_framer;

    localparam int IPG  = 12;
    localparam int MINF = 60;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_err = 1'b0;
    logic          in_ready;
    logic          tx_en;
    logic [7:0]    txd;
    logic          tx_er;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    gmii_tx_framer #(.IPG_BYTES(IPG), .MIN_FRAME(MINF), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
        .in_ready(in_ready),
        .tx_en(tx_en), .txd(txd), .tx_er(tx_er), .busy(busy),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #4 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wire monitor: captures every tx_en cycle, frame lengths and idle gaps.
    logic [7:0] cap_d[$];
    bit         cap_e[$];
    int         lens[$];
    int         gaps[$];
    int         run = 0;
    int         gap = 0;
    bit         prev_en = 1'b0;

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            if (!prev_en) begin
                gaps.push_back(gap);
                gap = 0;
            end
            cap_d.push_back(txd);
            cap_e.push_back(tx_er);
            run++;
            prev_en = 1'b1;
        end else begin
            if (prev_en) begin
                lens.push_back(run);
                run = 0;
            end
            gap++;
            prev_en = 1'b0;
        end
    end

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ d[j];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    task automatic accept_byte(output bit ok);
        bit rdy;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 2000);
        ok = rdy;
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input bit err,
                              input int urp, input int url);
        bit ok;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            in_sop   = (i == 0);
            in_eop   = (i == len - 1);
            in_err   = err && (i == len - 1);
            accept_byte(ok);
            if (!ok) break;
            if (i + 1 == urp && url > 0) begin
                in_valid = 1'b0;
                in_sop   = 1'b0;
                repeat (url) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 5000);
        if (busy) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic verify_frame(input string tag, input int len, input logic [7:0] base, input bit err,
                                input int urp, input int url, input int exp_txen, input int exp_er,
                                input bit fcs_known, input logic [31:0] fcs_exp);
        logic [7:0]  ed[$];
        bit          ee[$];
        logic [31:0] c;
        logic [31:0] fcs_got;
        logic [7:0]  b;
        logic [7:0]  d;
        bit          e;
        bit          bad;
        int          L;
        int          mism;
        int          ers;
        bad = err || (url > 0);
        for (int k = 0; k < 7; k++) begin ed.push_back(8'h55); ee.push_back(1'b0); end
        ed.push_back(8'hD5); ee.push_back(1'b0);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            ed.push_back(b); ee.push_back(1'b0);
            c = ref_crc(c, b);
            if (i + 1 == urp) begin
                for (int k = 0; k < url; k++) begin ed.push_back(8'h00); ee.push_back(1'b1); end
            end
        end
`ifdef GMII_TX_FRAMER_PAD_EN
        for (int k = len; k < MINF; k++) begin
            ed.push_back(8'h00); ee.push_back(1'b0);
            c = ref_crc(c, 8'h00);
        end
`endif
        c = ~c;
        for (int k = 0; k < 4; k++) begin ed.push_back(c[8*k +: 8]); ee.push_back(bad); end

        if (lens.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        L = lens.pop_front();
        chk({tag, "_txen_cycles"}, L, exp_txen);
        mism = 0;
        ers = 0;
        fcs_got = 32'd0;
        for (int j = 0; j < L; j++) begin
            d = cap_d.pop_front();
            e = cap_e.pop_front();
            if (e) ers++;
            if (j >= L - 4) fcs_got[8*(j-(L-4)) +: 8] = d;
            if (j < int'(ed.size()) && (d !== ed[j] || e !== ee[j])) begin
                if (mism == 0) $display("  %s first diff at cycle %0d: txd %0h er %0b, want %0h er %0b",
                                        tag, j, d, e, ed[j], ee[j]);
                mism++;
            end
        end
        chk({tag, "_stream_diffs"}, mism, 0);
        chk({tag, "_txer_cycles"}, ers, exp_er);
        if (fcs_known) chk({tag, "_fcs"}, fcs_got, fcs_exp);
    endtask

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         err;
        int         urp;
        int         url;
        int         exp_txen;
        int         exp_er;
        bit         fcs_known;
        logic [31:0] fcs;
    } vec_t;

    vec_t tbl[6];
    int   exp_fc;
    int   exp_ec;
    bit   ok;

    initial begin
`ifdef GMII_TX_FRAMER_PAD_EN
        tbl[0] = '{9,  8'h31, 1'b0, 0,  0, 72, 0, 1'b0, 32'h0};
        tbl[3] = '{30, 8'h20, 1'b0, 12, 3, 75, 7, 1'b0, 32'h0};
        tbl[4] = '{10, 8'hA0, 1'b0, 0,  0, 72, 0, 1'b0, 32'h0};
        tbl[5] = '{1,  8'h5A, 1'b0, 0,  0, 72, 0, 1'b0, 32'h0};
`else
        tbl[0] = '{9,  8'h31, 1'b0, 0,  0, 21, 0, 1'b1, 32'hCBF4_3926};
        tbl[3] = '{30, 8'h20, 1'b0, 12, 3, 45, 7, 1'b0, 32'h0};
        tbl[4] = '{10, 8'hA0, 1'b0, 0,  0, 22, 0, 1'b0, 32'h0};
        tbl[5] = '{1,  8'h5A, 1'b0, 0,  0, 13, 0, 1'b0, 32'h0};
`endif
        tbl[1] = '{64, 8'h00, 1'b0, 0,  0, 76, 0, 1'b0, 32'h0};
        tbl[2] = '{64, 8'h40, 1'b1, 0,  0, 76, 4, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_txd", txd, 0);
        chk("rst_tx_er", tx_er, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Stray bytes in IDLE are consumed; a sop is held back
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 8'hAA;
        #1;
        chk("idle_stray_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stray_no_tx", tx_en, 0);
        chk("idle_stray_busy", busy, 0);
        in_sop = 1'b1;
        #1;
        chk("idle_sop_ready", in_ready, 0);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted while data byte 20 is on the wire
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(i);
            in_sop   = (i == 0);
            in_eop   = 1'b0;
            accept_byte(ok);
        end
        chk("rst_mid_txd_before", txd, 8'h70 + 8'd19);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_tx_en", tx_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frame_cnt", frame_cnt, 0);
        chk("rst_mid_err_cnt", err_cnt, 0);
        @(negedge clk);
        #1;
        cap_d.delete();
        cap_e.delete();
        lens.delete();

        exp_fc = 0;
        exp_ec = 0;
        for (int v = 0; v < 6; v++) begin
            send_frame(tbl[v].len, tbl[v].base, tbl[v].err, tbl[v].urp, tbl[v].url);
            wait_idle();
            verify_frame($sformatf("v%0d", v), tbl[v].len, tbl[v].base, tbl[v].err, tbl[v].urp,
                         tbl[v].url, tbl[v].exp_txen, tbl[v].exp_er, tbl[v].fcs_known, tbl[v].fcs);
            exp_fc++;
            if (tbl[v].err || tbl[v].url > 0) exp_ec++;
            chk($sformatf("v%0d_frame_cnt", v), frame_cnt, exp_fc);
            chk($sformatf("v%0d_err_cnt", v), err_cnt, exp_ec);
        end

        // Back-to-back frames with the second sop already waiting
        gaps.delete();
        send_frame(64, 8'h10, 1'b0, 0, 0);
        send_frame(64, 8'h80, 1'b0, 0, 0);
        wait_idle();
        verify_frame("b2b_a", 64, 8'h10, 1'b0, 0, 0, 76, 0, 1'b0, 32'h0);
        verify_frame("b2b_b", 64, 8'h80, 1'b0, 0, 0, 76, 0, 1'b0, 32'h0);
        chk("b2b_gap", (gaps.size() > 1) ? gaps[1] : -1, IPG);
        exp_fc += 2;
        chk("b2b_frame_cnt", frame_cnt, exp_fc);
        chk("b2b_err_cnt", err_cnt, exp_ec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Transmit MAC framing stage. Directly feeds the GMII TX interface (`tx_en`/`txd`/`tx_er`).
- Accepts a byte-wide frame stream (`valid`/`ready`/`sop`/`eop`) from the MAC TX path.
- On the wire: preamble and SFD, then payload, optional padding to minimum size, then IEEE 802.3 CRC32 FCS, then the inter-packet gap.
- Drives `tx_er` on upstream underrun and on upstream-flagged errored frames.

Parameters:
- IPG_BYTES, 12, idle cycles (`tx_en`=0) enforced after every frame; legal range 1..255.
- MIN_FRAME, 60, minimum data+pad byte count before FCS; used only when padding is compiled in.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  GMII TX clock (125 MHz); all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_sop  input  1  first byte of frame; qualified by in_valid.
- in_eop  input  1  last byte of frame; qualified by in_valid.
- in_err  input  1  frame-bad flag; sampled with the in_eop byte.
- in_ready  output  1  byte accepted when in_valid & in_ready.
- tx_en  output  1  GMII transmit enable (registered).
- txd  output  8  GMII transmit data (registered).
- tx_er  output  1  GMII transmit error (registered).
- busy  output  1  high in any state other than IDLE.
- frame_cnt  output  CNT_W  frames completed (FCS sent); wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  frames with any `tx_er` cycle; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: `tx_en`=0, `txd`=0x00, `tx_er`=0, `in_ready`=0, `busy`=0, both counters 0, state IDLE, CRC register 0xFFFFFFFF.
- Reset mid-frame: outputs take reset values at the next edge and the frame is discarded. Counters do not increment for the discarded frame. Upstream must resend.

State machine: IDLE → PRE → SFD → DATA → [PAD] → FCS → IPG → IDLE.
- IDLE:
  - `in_ready`=1 only when !in_sop, so stray non-sop bytes are consumed and dropped.
  - in_valid & in_sop at edge T moves to PRE; the sop byte is not consumed.
  - `tx_en`=0.
- PRE: 7 cycles, `txd`=0x55, `tx_en`=1.
  - First 0x55 appears on `txd` at T+1.
- SFD: 1 cycle, `txd`=0xD5.
  - `in_ready` rises in this cycle, so the sop byte is consumed at the SFD edge and appears on `txd` one cycle later. No gap between SFD and the first data byte.
- DATA:
  - `in_ready`=1; each accepted byte appears on `txd` one cycle later.
  - Underrun (in_valid=0) drives `tx_en`=1, `tx_er`=1, `txd`=0x00 for that cycle. The frame is marked errored; underrun bytes are excluded from the CRC and byte count.
  - in_sop seen again in DATA is treated as a data byte; the bit is ignored.
  - Accepted in_eop goes to PAD (if enabled and byte count < MIN_FRAME), otherwise to FCS. `in_ready` drops the cycle after eop is accepted.
- PAD: `txd`=0x00 bytes included in the CRC until the byte count reaches MIN_FRAME.
- FCS: 4 cycles, `txd`= ~CRC bytes, LSB byte first.
  - If in_err was set with eop, or any underrun occurred, `tx_er`=1 on all 4 FCS cycles.
- IPG: `tx_en`=0, `tx_er`=0, `txd`=0x00 for exactly IPG_BYTES cycles.
  - frame_cnt increments on the first IPG cycle; err_cnt also increments there if the frame is errored.
  - After IPG, return to IDLE. A waiting sop starts PRE in the next cycle, so the minimum gap equals IPG_BYTES.

CRC and counting:
- CRC32 is reflected, polynomial 0xEDB88320, initial 0xFFFFFFFF, computed over data+pad bytes. It is re-initialised in SFD.
- Byte counter is 16-bit and saturates at 0xFFFF. No maximum-length enforcement (upstream responsibility).
- `tx_en` is contiguous from the first preamble byte through the last FCS byte.

Optional Feature:
- Macro: GMII_TX_FRAMER_PAD_EN.
- Defined: frames shorter than MIN_FRAME data bytes are zero-padded to MIN_FRAME before the FCS, and the pad bytes are included in the CRC.
- Undefined: PAD state and compare logic are absent; FCS follows the last data byte directly regardless of length. MIN_FRAME is unused.

Test Plan:
- No PAD_EN; send 9 bytes "123456789" (0x31..0x39) with no underrun → txd = 7×0x55, 0xD5, 0x31..0x39, 0x26 0x39 0xF4 0xCB. `tx_en` high exactly 21 cycles, `tx_er` never asserted, frame_cnt=1.
- PAD_EN; 10-byte frame → 10 data bytes, then 50×0x00, then 4 FCS bytes. `tx_en` high 72 cycles.
- Two 64-byte frames, in_valid held high, second sop waiting → `tx_en` low exactly 12 cycles between the frames. frame_cnt=2, err_cnt=0.
- Deassert in_valid for 3 cycles mid-DATA → `tx_er`=1 with `txd`=0x00 for exactly those 3 cycles, `tx_er`=1 on all 4 FCS bytes, err_cnt=1, `tx_en` stays contiguous.
- Assert in_err with in_eop on a 64-byte frame → data cycles clean, `tx_er`=1 only on the 4 FCS cycles, err_cnt increments.
- Assert reset for 1 cycle at data byte 20 → next edge `tx_en`=0, `busy`=0, frame_cnt unchanged. A subsequent frame transmits correctly with the right FCS.
